// File: rtl/mem_bus_pkg.sv
// mem_bus_pkg: shared types and lane-alignment helpers for the memory-bus initiator
package mem_bus_pkg;
    typedef enum logic [1:0] {SZ_BYTE = 2'd0, SZ_HALF = 2'd1, SZ_WORD = 2'd2} size_e;
    typedef enum logic [1:0] {IDLE, LA, WAIT, RESP} state_e;

    // Size 3 is never legal; halves and words must sit on their natural boundary.
    function automatic logic is_illegal(input logic [1:0] size, input logic [1:0] addr_lo);
        return size == 2'd3 || (size == SZ_HALF && addr_lo[0]) || (size == SZ_WORD && addr_lo != 2'b00);
    endfunction

    function automatic logic [3:0] gen_wstrb(input logic [1:0] size, input logic [1:0] addr_lo);
        return size == SZ_BYTE ? 4'b0001 << addr_lo : size == SZ_HALF ? 4'b0011 << addr_lo : 4'b1111;
    endfunction

    function automatic logic [31:0] lane_replicate(input logic [1:0] size, input logic [31:0] wdata);
        return size == SZ_BYTE ? {4{wdata[7:0]}} : size == SZ_HALF ? {2{wdata[15:0]}} : wdata;
    endfunction

    function automatic logic [31:0] extract_load(input logic [1:0] size, input logic sgn,
                                                 input logic [1:0] addr_lo, input logic [31:0] rdata);
        logic [7:0]  b;
        logic [15:0] h;
        b = 8'(rdata >> {addr_lo, 3'b000});
        h = 16'(rdata >> {addr_lo[1], 4'b0000});
        return size == SZ_BYTE ? {{24{sgn & b[7]}}, b} : size == SZ_HALF ? {{16{sgn & h[15]}}, h} : rdata;
    endfunction
endpackage

// File: rtl/mem_bus_align.sv
// mem_bus_align: combinational store-lane replication, strobe generation and load extension
// Ports: i_size/i_signed/i_addr_lo describe the access; i_wdata store data (LSB-justified);
//        i_rdata raw bus word; o_wstrb strobes, o_wdata replicated lanes, o_load extended result
module mem_bus_align
    import mem_bus_pkg::*;
(
    input  logic [1:0]  i_size,
    input  logic        i_signed,
    input  logic [1:0]  i_addr_lo,
    input  logic [31:0] i_wdata,
    input  logic [31:0] i_rdata,
    output logic [3:0]  o_wstrb,
    output logic [31:0] o_wdata,
    output logic [31:0] o_load
);
    assign o_wstrb = gen_wstrb(i_size, i_addr_lo);
    assign o_wdata = lane_replicate(i_size, i_wdata);
    assign o_load  = extract_load(i_size, i_signed, i_addr_lo, i_rdata);
endmodule

// File: rtl/mem_bus_initiator.sv
// mem_bus_initiator: PicoRV32 native-bus master running one aligned load/store at a time
// Ports: i_clk/i_reset; i_cmd_*/o_cmd_ready command port; o_rsp_*/i_rsp_ready response port;
//        o_mem_*/i_mem_* native bus (registered); o_mem_la_* look-ahead, active only in the LA cycle
module mem_bus_initiator
    import mem_bus_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 64,
    parameter bit INSTR_FETCH    = 1'b0
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_cmd_valid,
    output logic        o_cmd_ready,
    input  logic        i_cmd_write,
    input  logic [1:0]  i_cmd_size,
    input  logic        i_cmd_signed,
    input  logic [31:0] i_cmd_addr,
    input  logic [31:0] i_cmd_wdata,
    output logic        o_rsp_valid,
    input  logic        i_rsp_ready,
    output logic [31:0] o_rsp_rdata,
    output logic        o_rsp_error,
    output logic        o_mem_valid,
    output logic        o_mem_instr,
    input  logic        i_mem_ready,
    output logic [31:0] o_mem_addr,
    output logic [31:0] o_mem_wdata,
    output logic [3:0]  o_mem_wstrb,
    input  logic [31:0] i_mem_rdata,
    output logic        o_mem_la_read,
    output logic        o_mem_la_write,
    output logic [31:0] o_mem_la_addr,
    output logic [31:0] o_mem_la_wdata,
    output logic [3:0]  o_mem_la_wstrb
);
    localparam int CW = $clog2(TIMEOUT_CYCLES);

    state_e        r_state;
    logic          r_write;
    logic          r_signed;
    logic [1:0]    r_size;
    logic [31:0]   r_addr;
    logic [31:0]   r_wdata;
    logic [CW-1:0] r_cnt;
    logic          r_mem_valid;
    logic [31:0]   r_mem_addr;
    logic [31:0]   r_mem_wdata;
    logic [3:0]    r_mem_wstrb;
    logic          r_rsp_valid;
    logic          r_rsp_error;
    logic [31:0]   r_rsp_rdata;
    logic [3:0]    w_wstrb;
    logic [31:0]   w_wdata;
    logic [31:0]   w_load;
    logic          w_la;

    mem_bus_align u_align (
        .i_size    (r_size),
        .i_signed  (r_signed),
        .i_addr_lo (r_addr[1:0]),
        .i_wdata   (r_wdata),
        .i_rdata   (i_mem_rdata),
        .o_wstrb   (w_wstrb),
        .o_wdata   (w_wdata),
        .o_load    (w_load)
    );

    assign w_la           = r_state == LA;
    assign o_cmd_ready    = r_state == IDLE;
    assign o_rsp_valid    = r_rsp_valid;
    assign o_rsp_rdata    = r_rsp_rdata;
    assign o_rsp_error    = r_rsp_error;
    assign o_mem_valid    = r_mem_valid;
    assign o_mem_instr    = INSTR_FETCH;
    assign o_mem_addr     = r_mem_addr;
    assign o_mem_wdata    = r_mem_wdata;
    assign o_mem_wstrb    = r_mem_wstrb;
    assign o_mem_la_read  = w_la && !r_write;
    assign o_mem_la_write = w_la && r_write;
    assign o_mem_la_addr  = w_la ? {r_addr[31:2], 2'b00} : '0;
    assign o_mem_la_wdata = w_la ? w_wdata : '0;
    assign o_mem_la_wstrb = (w_la && r_write) ? w_wstrb : '0;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state     <= IDLE;
            r_write     <= 1'b0;
            r_signed    <= 1'b0;
            r_size      <= 2'd0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_cnt       <= '0;
            r_mem_valid <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_mem_wstrb <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_error <= 1'b0;
            r_rsp_rdata <= '0;
        end else begin
            case (r_state)
                IDLE: if (i_cmd_valid) begin
                    r_write  <= i_cmd_write;
                    r_signed <= i_cmd_signed;
                    r_size   <= i_cmd_size;
                    r_addr   <= i_cmd_addr;
                    r_wdata  <= i_cmd_wdata;
                    r_cnt    <= '0;
                    // Illegal commands answer immediately without touching the bus.
                    if (is_illegal(i_cmd_size, i_cmd_addr[1:0])) begin
                        r_state     <= RESP;
                        r_rsp_valid <= 1'b1;
                        r_rsp_error <= 1'b1;
                        r_rsp_rdata <= '0;
                    end else begin
                        r_state <= LA;
                    end
                end
                LA: begin
                    r_mem_valid <= 1'b1;
                    r_mem_addr  <= {r_addr[31:2], 2'b00};
                    r_mem_wdata <= w_wdata;
                    r_mem_wstrb <= r_write ? w_wstrb : 4'b0000;
                    r_state     <= WAIT;
                end
                WAIT: if (i_mem_ready) begin
                    // A ready on the timeout cycle still completes normally.
                    r_mem_valid <= 1'b0;
                    r_rsp_valid <= 1'b1;
                    r_rsp_error <= 1'b0;
                    r_rsp_rdata <= r_write ? '0 : w_load;
                    r_state     <= RESP;
                end else if (r_cnt == CW'(TIMEOUT_CYCLES - 1)) begin
                    r_mem_valid <= 1'b0;
                    r_rsp_valid <= 1'b1;
                    r_rsp_error <= 1'b1;
                    r_rsp_rdata <= '0;
                    r_state     <= RESP;
                end else begin
                    r_cnt <= r_cnt + CW'(1);
                end
                RESP: if (i_rsp_ready) begin
                    r_rsp_valid <= 1'b0;
                    r_state     <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_bus_initiator.sv
// tb_mem_bus_initiator: directed plus randomized checks of the initiator against a byte-array memory model
module tb_mem_bus_initiator;
    localparam int T = 8;

    logic        clk = 1'b0;
    logic        reset;
    logic        cmd_valid, cmd_ready, cmd_write, cmd_signed;
    logic [1:0]  cmd_size;
    logic [31:0] cmd_addr, cmd_wdata;
    logic        rsp_valid, rsp_ready, rsp_error;
    logic [31:0] rsp_rdata;
    logic        mem_valid, mem_instr, mem_ready;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_wstrb;
    logic        la_read, la_write;
    logic [31:0] la_addr, la_wdata;
    logic [3:0]  la_wstrb;

    logic [7:0]  ref_mem [1024];
    logic [31:0] bus_mem [256];
    int          rdy_lat;
    int          wcnt;
    bit          tie_hi;
    int          checks = 0;
    int          errors = 0;
    logic [31:0] last_rd, last_wd;
    logic [3:0]  last_ws;
    logic        last_err;
    int          last_mv;

    mem_bus_initiator #(.TIMEOUT_CYCLES(T), .INSTR_FETCH(1'b0)) dut (
        .i_clk(clk), .i_reset(reset),
        .i_cmd_valid(cmd_valid), .o_cmd_ready(cmd_ready), .i_cmd_write(cmd_write),
        .i_cmd_size(cmd_size), .i_cmd_signed(cmd_signed), .i_cmd_addr(cmd_addr), .i_cmd_wdata(cmd_wdata),
        .o_rsp_valid(rsp_valid), .i_rsp_ready(rsp_ready), .o_rsp_rdata(rsp_rdata), .o_rsp_error(rsp_error),
        .o_mem_valid(mem_valid), .o_mem_instr(mem_instr), .i_mem_ready(mem_ready),
        .o_mem_addr(mem_addr), .o_mem_wdata(mem_wdata), .o_mem_wstrb(mem_wstrb), .i_mem_rdata(mem_rdata),
        .o_mem_la_read(la_read), .o_mem_la_write(la_write), .o_mem_la_addr(la_addr),
        .o_mem_la_wdata(la_wdata), .o_mem_la_wstrb(la_wstrb)
    );

    always #5 clk = ~clk;

    // Responder: ready after rdy_lat cycles of mem_valid (never if negative), or tied high.
    assign mem_ready = tie_hi || (mem_valid && rdy_lat >= 0 && wcnt >= rdy_lat);
    assign mem_rdata = bus_mem[mem_addr[9:2]];

    always @(posedge clk) begin
        if (reset) begin
            wcnt <= 0;
            for (int i = 0; i < 256; i++)
                bus_mem[i] <= {ref_mem[4*i+3], ref_mem[4*i+2], ref_mem[4*i+1], ref_mem[4*i]};
        end else begin
            wcnt <= mem_valid ? wcnt + 1 : 0;
            if (mem_valid && mem_ready)
                for (int j = 0; j < 4; j++)
                    if (mem_wstrb[j]) bus_mem[mem_addr[9:2]][8*j +: 8] <= mem_wdata[8*j +: 8];
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic run(input bit wr, input logic [1:0] sz, input bit sg, input logic [31:0] a,
                       input logic [31:0] wd, input int lat, input int hold);
        int          n, c, mv, first_mv, la_n, la_c;
        bit          bad, to, unstable, done;
        logic [31:0] e_rd, e_wd, la_a, la_d, m_a, m_d, r_d;
        logic [3:0]  e_st, la_s, m_s;
        logic        la_w;
        n    = 1 << sz;
        bad  = sz == 2'd3 || (a % n) != 0;
        to   = !bad && (lat < 0 || lat >= T);
        e_st = '0;
        e_wd = '0;
        e_rd = '0;
        for (int k = 0; k < n && !bad; k++) e_st[(a % 4) + k] = 1'b1;
        for (int j = 0; j < 4; j++) e_wd[8*j +: 8] = wd[8*(j % n) +: 8];
        if (!wr) e_st = '0;
        if (!bad && !to && !wr) begin
            for (int k = 0; k < n; k++) e_rd |= 32'(ref_mem[a + k]) << (8 * k);
            if (sg && n < 4 && e_rd[8*n-1]) e_rd |= 32'hFFFF_FFFF << (8 * n);
        end
        if (!bad && !to && wr)
            for (int k = 0; k < n; k++) ref_mem[a + k] = wd[8*k +: 8];
        rdy_lat = lat;
        @(negedge clk);
        check("cmd_ready_idle", cmd_ready, 1);
        cmd_valid = 1; cmd_write = wr; cmd_size = sz; cmd_signed = sg; cmd_addr = a; cmd_wdata = wd;
        @(posedge clk);
        #1 cmd_valid = 0;
        c = 0; mv = 0; first_mv = 0; la_n = 0; la_c = 0; unstable = 0; done = 0;
        la_w = 0; la_a = 0; la_d = 0; la_s = 0; m_a = 0; m_d = 0; m_s = 0;
        while (!done && c < 100) begin
            @(negedge clk);
            c++;
            if (la_read || la_write) begin
                la_n++; la_c = c; la_w = la_write; la_a = la_addr; la_d = la_wdata; la_s = la_wstrb;
            end
            if (mem_valid) begin
                if (mv == 0) begin
                    first_mv = c; m_a = mem_addr; m_d = mem_wdata; m_s = mem_wstrb;
                end else if ({mem_addr, mem_wdata, mem_wstrb} !== {m_a, m_d, m_s}) unstable = 1;
                mv++;
            end
            done = rsp_valid;
        end
        check("rsp_seen", done, 1);
        if (bad) begin
            check("err_latency", c, 1);
            check("err_no_bus", la_n + mv, 0);
        end else begin
            check("la_once", la_n, 1);
            check("la_cycle", la_c, 1);
            check("la_dir", la_w, wr);
            check("la_addr", la_a, {a[31:2], 2'b00});
            check("la_wstrb", la_s, e_st);
            check("mv_first", first_mv, 2);
            check("mv_cycles", mv, to ? T : lat + 1);
            check("mem_stable", unstable, 0);
            check("mem_addr", m_a, {a[31:2], 2'b00});
            check("mem_wstrb", m_s, e_st);
            check("rsp_latency", c, mv + 2);
            if (wr) begin
                check("la_wdata", la_d, e_wd);
                check("mem_wdata", m_d, e_wd);
            end
        end
        check("rsp_error", rsp_error, bad || to);
        check("rsp_rdata", rsp_rdata, e_rd);
        last_rd = rsp_rdata; last_err = rsp_error; last_ws = m_s; last_wd = m_d; last_mv = mv;
        r_d = rsp_rdata;
        repeat (hold) begin
            @(negedge clk);
            check("hold_valid", rsp_valid, 1);
            check("hold_rdata", rsp_rdata, r_d);
            check("hold_cmd_ready", cmd_ready, 0);
        end
        rsp_ready = 1;
        @(posedge clk);
        #1 rsp_ready = 0;
        @(negedge clk);
        check("rsp_consumed", {rsp_valid, cmd_ready}, 2'b01);
    endtask

    initial begin
        reset = 1; cmd_valid = 0; cmd_write = 0; cmd_size = 0; cmd_signed = 0;
        cmd_addr = 0; cmd_wdata = 0; rsp_ready = 0; tie_hi = 0; rdy_lat = 0;
        for (int i = 0; i < 1024; i++) ref_mem[i] = 8'($urandom);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_flags", {mem_valid, la_read, la_write, rsp_valid, rsp_error, cmd_ready, mem_instr}, 7'b0000010);
        check("rst_bus", mem_addr | mem_wdata | la_addr | la_wdata | rsp_rdata | {24'd0, mem_wstrb, la_wstrb}, 0);
        reset = 0;

        run(1, 2'd2, 0, 32'h100, 32'hDEAD_BEEF, 0, 1);
        check("sw_wstrb", last_ws, 4'hF);
        run(0, 2'd2, 0, 32'h100, 32'h0, 0, 0);
        check("lw_value", last_rd, 32'hDEAD_BEEF);

        run(1, 2'd0, 0, 32'h103, 32'h0000_0080, 1, 0);
        check("sb_wstrb", last_ws, 4'b1000);
        check("sb_wdata", last_wd, 32'h8080_8080);
        run(0, 2'd0, 1, 32'h103, 32'h0, 0, 0);
        check("lb_signed", last_rd, 32'hFFFF_FF80);
        run(0, 2'd0, 0, 32'h103, 32'h0, 2, 0);
        check("lb_unsigned", last_rd, 32'h0000_0080);

        run(1, 2'd1, 0, 32'h202, 32'h0000_1234, 0, 0);
        check("sh_wstrb", last_ws, 4'b1100);
        run(0, 2'd2, 0, 32'h200, 32'h0, 0, 0);
        check("lw_upper_half", last_rd[31:16], 16'h1234);
        run(0, 2'd1, 1, 32'h202, 32'h0, 0, 0);
        check("lh_signed", last_rd, 32'h0000_1234);

        run(0, 2'd2, 0, 32'h101, 32'h0, 0, 0);
        tie_hi = 1;
        run(0, 2'd3, 0, 32'h100, 32'h0, 0, 0);
        tie_hi = 0;

        run(0, 2'd2, 0, 32'h104, 32'h0, -1, 0);
        check("timeout_err", last_err, 1);
        check("timeout_mv", last_mv, T);
        run(0, 2'd2, 0, 32'h104, 32'h0, T - 1, 0);
        check("late_ready_err", last_err, 0);

        run(0, 2'd0, 1, 32'h103, 32'h0, 2, 5);

        rdy_lat = -1;
        @(negedge clk);
        cmd_valid = 1; cmd_write = 0; cmd_size = 2'd2; cmd_signed = 0; cmd_addr = 32'h40;
        @(posedge clk);
        #1 cmd_valid = 0;
        repeat (3) @(negedge clk);
        check("wait_mv", mem_valid, 1);
        reset = 1;
        @(posedge clk);
        @(negedge clk);
        check("midrst_flags", {mem_valid, rsp_valid, cmd_ready, la_read, la_write}, 5'b00100);
        reset = 0;
        repeat (T + 2) @(negedge clk);
        check("midrst_lost", {mem_valid, rsp_valid, cmd_ready}, 3'b001);

        for (int it = 0; it < 40; it++) begin
            logic [1:0]  sz;
            logic [31:0] a;
            int          lat;
            sz = 2'($urandom_range(0, 3));
            a  = 32'($urandom_range(0, 1023));
            if (sz != 2'd3 && $urandom_range(0, 3) != 0) a = a & ~((32'd1 << sz) - 1);
            lat = $urandom_range(0, 10);
            if (lat == 10) lat = -1;
            tie_hi = $urandom_range(0, 7) == 0;
            if (tie_hi) lat = 0;
            run(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), a, $urandom, lat, $urandom_range(0, 2));
        end
        tie_hi = 0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/mem_bus_initiator.md
Name: mem_bus_initiator

Overview:
- Initiator side of the PicoRV32 native memory interface, including the look-ahead (mem_la_*) signals consumed by the memory-model responder.
- Accepts byte/half/word load and store commands over a valid/ready port and performs alignment, strobe generation and sign extension.
- Runs one bus transaction at a time and returns a response (read data or write acknowledge) with an error flag.
- Drives the memory model in testbenches that do not instantiate the CPU, and serves as a simple DMA/debug master.

Parameters:
- TIMEOUT_CYCLES, 64: cycles to wait for mem_ready before aborting with error; must be ≥ 2.
- INSTR_FETCH, 0: constant value driven on mem_instr.

Ports:
- clk  in  1  clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  command accepted when cmd_valid && cmd_ready.
- cmd_write  in  1  1 = store, 0 = load.
- cmd_size  in  2  0 = byte, 1 = half, 2 = word, 3 = illegal.
- cmd_signed  in  1  sign-extend load result.
- cmd_addr  in  32  byte address.
- cmd_wdata  in  32  store data, LSB-justified.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  response consumed.
- rsp_rdata  out  32  load result, extended; 0 for stores and errors.
- rsp_error  out  1  misaligned, illegal size, or timeout.
- mem_valid  out  1  bus request.
- mem_instr  out  1  fixed at INSTR_FETCH.
- mem_ready  in  1  responder done.
- mem_addr  out  32  word-aligned address (bits [1:0] = 0).
- mem_wdata  out  32  lane-replicated store data.
- mem_wstrb  out  4  byte strobes; 0 for reads.
- mem_rdata  in  32  read data.
- mem_la_read  out  1  look-ahead read pulse.
- mem_la_write  out  1  look-ahead write pulse.
- mem_la_addr  out  32  look-ahead address (same value as mem_addr).
- mem_la_wdata  out  32  look-ahead write data.
- mem_la_wstrb  out  4  look-ahead strobes.

Behaviour:
- Reset: state IDLE. cmd_ready=1. rsp_valid=0, rsp_rdata=0, rsp_error=0. mem_valid=0, mem_addr=0, mem_wdata=0, mem_wstrb=0. mem_la_read=0, mem_la_write=0, mem_la_addr/wdata/wstrb=0. Timeout counter=0.
- Reset mid-transaction: forces IDLE the next cycle and drops mem_valid and rsp_valid; the response is lost.
- FSM states: IDLE, LA, WAIT, RESP.
- IDLE: cmd_ready=1. On handshake, capture the command and check legality:
  - size=3, or half with addr[0]=1, or word with addr[1:0]≠0: go directly to RESP with rsp_error=1, rsp_rdata=0. No bus activity.
  - Otherwise go to LA.
- LA (exactly 1 cycle):
  - mem_la_read = !write; mem_la_write = write.
  - mem_la_addr = {addr[31:2], 2'b00}.
  - mem_la_wdata: byte → {4{wdata[7:0]}}; half → {2{wdata[15:0]}}; word → wdata.
  - mem_la_wstrb (stores only): byte → 4'b0001 << addr[1:0]; half → 4'b0011 << addr[1:0]; word → 4'b1111. Reads drive 0.
  - Registered mem_* copies load at the end of LA. Next state WAIT.
- WAIT:
  - mem_valid=1; mem_addr/mem_wdata/mem_wstrb hold stable; mem_la_read/mem_la_write=0.
  - If mem_ready is high in a cycle with mem_valid=1, the transfer completes that cycle. mem_ready may already be high on WAIT entry, giving completion in the first WAIT cycle.
  - On completion: capture mem_rdata and extract the lane by addr[1:0] (byte: rdata >> 8*addr[1:0]; half: rdata >> 16*addr[1]). Zero- or sign-extend per cmd_signed. Stores return rsp_rdata=0. Drop mem_valid. Go to RESP with error=0.
  - The counter increments each WAIT cycle without mem_ready. When it reaches TIMEOUT_CYCLES-1 without completion, drop mem_valid, set rsp_error=1, rsp_rdata=0, go to RESP.
  - mem_ready arriving on the same cycle as the timeout wins: the transfer completes normally.
- RESP:
  - rsp_valid=1; rsp_rdata and rsp_error held stable; cmd_ready=0.
  - On rsp_ready: rsp_valid=0 and go to IDLE.
  - No new command is accepted in the same cycle (min 4 cycles per bus command, 2 per error command).
- Latency: command handshake → mem_valid is 2 cycles. With mem_ready tied high, handshake → rsp_valid is 3 cycles.
- mem_ready outside WAIT is ignored.
- Counter clears on entry to LA.

Decomposition:
- Package mem_bus_pkg holds:
  - size_e (SZ_BYTE=0, SZ_HALF=1, SZ_WORD=2).
  - state_e (IDLE, LA, WAIT, RESP).
  - Function gen_wstrb(size, addr_lo).
  - Function lane_replicate(size, wdata).
  - Function extract_load(size, signed, addr_lo, rdata).
- One sub-module, mem_bus_align: purely combinational alignment/extension, wrapping the package functions so they can be unit-tested separately.

Test Plan:
- Store word 0xDEADBEEF at 0x100, then load word 0x100 against the memory model → LA cycle shows la_write=1, la_wstrb=4'hF, la_addr=0x100; load returns rsp_rdata=0xDEADBEEF, error=0.
- Store byte 0x80 at 0x103, then signed load byte 0x103 → mem_wstrb=4'b1000, mem_wdata=0x80808080; rsp_rdata=0xFFFFFF80. Unsigned load of the same byte → 0x00000080.
- Store half 0x1234 at 0x202, then load word 0x200 → wstrb=4'b1100; word read shows 0x1234 in bits [31:16]; signed half load at 0x202 → 0x00001234.
- Load word at 0x101, and separately cmd_size=3 → rsp_error=1, rsp_rdata=0; mem_valid and mem_la_* never assert.
- mem_ready held 0, TIMEOUT_CYCLES=8 → mem_valid high exactly 8 cycles, then rsp_error=1. Repeat with mem_ready rising on the 8th cycle → error=0.
- Assert reset during WAIT, and hold rsp_ready=0 for 5 cycles in RESP → reset: mem_valid=0 and IDLE next cycle. Hold: rsp_valid and rsp_rdata stable, cmd_ready=0 throughout.
